control_sequencer: RTL and testbench

Control-side counterpart of the datapath: accepts encoded instructions over a valid/ready handshake and drives the datapath's 16-bit control word, one word per clock. Reads back the datapath's 4-bit status flags to resolve conditional instructions. Sits between the instruction source and the processing unit and owns all sequencing: single issue, repeated issue, flag-conditional issue, and halt.

---
 rtl/control_sequencer_pkg.sv | 56 +++++
 rtl/control_sequencer_if.sv | 36 +++
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types, field positions and helpers for the control sequencer.
// Instruction and control-word layouts are fixed by the datapath.
package control_pkg;

    typedef enum logic [1:0] {
        K_EXEC   = 2'd0,
        K_REPEAT = 2'd1,
        K_COND   = 2'd2,
        K_HALT   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_REPEAT,
        ST_HALT
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam int I_KIND_LSB = 17;
    localparam int I_SEL_LSB  = 13;
    localparam int I_F_LSB    = 9;
    localparam int I_D_LSB    = 6;
    localparam int I_A_LSB    = 3;
    localparam int I_B_LSB    = 0;

    localparam int C_A_LSB = 13;
    localparam int C_B_LSB = 10;
    localparam int C_D_LSB = 7;
    localparam int C_F_LSB = 3;
    localparam int C_H_LSB = 0;

    localparam logic [15:0] CTRL_NOP = 16'h0000;

    function automatic logic [15:0] pack_ctrl(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic [2:0] d,
        input logic [3:0] f,
        input logic [2:0] h
    );
        logic [15:0] w;
        w = CTRL_NOP;
        w[C_A_LSB +: 3] = a;
        w[C_B_LSB +: 3] = b;
        w[C_D_LSB +: 3] = d;
        w[C_F_LSB +: 4] = f;
        w[C_H_LSB +: 3] = h;
        return w;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction handshake plus datapath control/status bundle.
// slave = sequencer side, master = instruction source and datapath.
interface control_sequencer_if;

    logic [18:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  out_flags;
    logic [15:0] ctrl_word;
    logic        ctrl_valid;
    logic        halted;
    logic [7:0]  issue_count;

    modport slave (
        input  instr_data,
        input  instr_valid,
        input  out_flags,
        output instr_ready,
        output ctrl_word,
        output ctrl_valid,
        output halted,
        output issue_count
    );

    modport master (
        output instr_data,
        output instr_valid,
        output out_flags,
        input  instr_ready,
        input  ctrl_word,
        input  ctrl_valid,
        input  halted,
        input  issue_count
    );

endinterface

// File: rtl/control_sequencer.sv
// Issues one datapath control word per clock from encoded instructions:
// single, repeated, flag-conditional issue and halt.
module control_sequencer
    import control_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    control_sequencer_if.slave bus
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_ctrl_word;
    logic [15:0] w_word_nxt;
    logic        r_ctrl_valid;
    logic        w_valid_nxt;
    logic        r_halted;
    logic        w_halted_nxt;
    logic [7:0]  r_issue_count;
    logic [3:0]  r_flag_q;
    logic [3:0]  r_rpt_left;
    logic [3:0]  w_rpt_nxt;

    kind_e       w_kind;
    logic [3:0]  w_sel;
    logic [3:0]  w_f;
    logic [2:0]  w_a;
    logic [2:0]  w_b;
    logic [2:0]  w_d;
    logic [3:0]  w_eff;
    logic [15:0] w_word;
    logic        w_ready;
    logic        w_accept;
    logic        w_cond_ok;

    assign w_kind = kind_e'(bus.instr_data[I_KIND_LSB +: 2]);
    assign w_sel  = bus.instr_data[I_SEL_LSB +: 4];
    assign w_f    = bus.instr_data[I_F_LSB +: 4];
    assign w_d    = bus.instr_data[I_D_LSB +: 3];
    assign w_a    = bus.instr_data[I_A_LSB +: 3];
    assign w_b    = bus.instr_data[I_B_LSB +: 3];
    assign w_word = pack_ctrl(w_a, w_b, w_d, w_f, 3'b000);

    assign w_ready  = !r_halted && (r_rpt_left == 4'd0);
    assign w_accept = bus.instr_valid && w_ready;

    // Flags of a live word are only on out_flags while it is valid.
    assign w_eff     = r_ctrl_valid ? bus.out_flags : r_flag_q;
    assign w_cond_ok = (w_eff[w_sel[1:0]] == w_sel[2]);

    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_word_nxt   = CTRL_NOP;
        w_valid_nxt  = 1'b0;
        w_halted_nxt = r_halted;
        w_rpt_nxt    = r_rpt_left;
        unique case (r_state)
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            ST_REPEAT: begin
                w_word_nxt  = r_ctrl_word;
                w_valid_nxt = 1'b1;
                w_rpt_nxt   = r_rpt_left - 4'd1;
                w_state_nxt = (r_rpt_left > 4'd1) ? ST_REPEAT : ST_ISSUE;
            end
            default: begin
                if (w_accept) begin
                    unique case (w_kind)
                        K_EXEC: begin
                            w_state_nxt = ST_ISSUE;
                            w_word_nxt  = pack_ctrl(w_a, w_b, w_d, w_f,
                                                    w_sel[2:0]);
                            w_valid_nxt = 1'b1;
                        end
                        K_REPEAT: begin
                            w_word_nxt  = w_word;
                            w_valid_nxt = 1'b1;
                            w_rpt_nxt   = w_sel;
                            w_state_nxt = (w_sel != 4'd0) ? ST_REPEAT
                                                          : ST_ISSUE;
                        end
                        K_COND: begin
                            w_state_nxt = ST_ISSUE;
                            if (w_cond_ok) begin
                                w_word_nxt  = w_word;
                                w_valid_nxt = 1'b1;
                            end
                        end
                        K_HALT: begin
                            w_state_nxt  = ST_HALT;
                            w_halted_nxt = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ctrl_word   <= CTRL_NOP;
            r_ctrl_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_issue_count <= 8'd0;
            r_flag_q      <= 4'd0;
            r_rpt_left    <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ctrl_word  <= w_word_nxt;
            r_ctrl_valid <= w_valid_nxt;
            r_halted     <= w_halted_nxt;
            r_rpt_left   <= w_rpt_nxt;
            if (r_ctrl_valid) begin
                r_flag_q      <= bus.out_flags;
                r_issue_count <= r_issue_count + 8'd1;
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.ctrl_word   = r_ctrl_word;
    assign bus.ctrl_valid  = r_ctrl_valid;
    assign bus.halted      = r_halted;
    assign bus.issue_count = r_issue_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_control_sequencer;
    import control_pkg::*;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    control_sequencer_if sif();

    control_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // EXEC sel=0101 F=0010 D=011 A=001 B=010 -> {001,010,011,0010,101}
    localparam logic [18:0] I_EXEC = 19'b00_0101_0010_011_001_010;
    localparam logic [18:0] I_RPT3 = 19'b01_0011_0010_011_001_010;
    localparam logic [18:0] I_RPT5 = 19'b01_0101_0010_011_001_010;
    localparam logic [18:0] I_CZ1  = 19'b10_0100_0010_011_001_010;
    localparam logic [18:0] I_CZ0  = 19'b10_0000_0010_011_001_010;
    localparam logic [18:0] I_CC1  = 19'b10_0101_0010_011_001_010;
    localparam logic [18:0] I_CC0  = 19'b10_0001_0010_011_001_010;
    localparam logic [18:0] I_HALT = 19'b11_0000_0000_000_000_000;
    localparam logic [15:0] W_EXEC = 16'h2995;
    localparam logic [15:0] W_H0   = 16'h2990;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] w,
                           input logic v, input logic [7:0] cnt);
        chk({tag, ".word"}, 32'(sif.ctrl_word), 32'(w));
        chk({tag, ".valid"}, 32'(sif.ctrl_valid), 32'(v));
        chk({tag, ".count"}, 32'(sif.issue_count), 32'(cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        sif.instr_data  = '0;
        sif.instr_valid = 1'b0;
        sif.out_flags   = 4'd0;
        #12;
        chk_out("rst", 16'h0000, 1'b0, 8'd0);
        chk("rst.halted", 32'(sif.halted), 32'd0);
        chk("rst.ready", 32'(sif.instr_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // single EXEC
        sif.instr_data  = I_EXEC;
        sif.instr_valid = 1'b1;
        tick();
        sif.instr_valid = 1'b0;
        chk_out("exec", W_EXEC, 1'b1, 8'd0);
        tick();
        chk_out("exec.nop", 16'h0000, 1'b0, 8'd1);

        // REPEAT sel=3 with EXEC held behind it
        sif.instr_data  = I_RPT3;
        sif.instr_valid = 1'b1;
        tick();
        sif.instr_data = I_EXEC;
        for (int i = 1; i <= 3; i++) begin
            chk("rpt.word", 32'(sif.ctrl_word), 32'(W_H0));
            chk("rpt.ready_lo", 32'(sif.instr_ready), 32'd0);
            tick();
        end
        chk("rpt.last", 32'(sif.ctrl_word), 32'(W_H0));
        chk("rpt.ready_hi", 32'(sif.instr_ready), 32'd1);
        tick();
        sif.instr_valid = 1'b0;
        chk_out("rpt.next", W_EXEC, 1'b1, 8'd5);
        tick();
        chk_out("rpt.done", 16'h0000, 1'b0, 8'd6);

        // back-to-back COND on live Z
        sif.instr_data  = I_EXEC;
        sif.instr_valid = 1'b1;
        tick();
        sif.out_flags  = 4'b0001;
        sif.instr_data = I_CZ1;
        tick();
        chk_out("cz1", W_H0, 1'b1, 8'd7);
        sif.instr_data = I_CZ0;
        tick();
        sif.instr_valid = 1'b0;
        sif.out_flags   = 4'b0000;
        chk_out("cz0", 16'h0000, 1'b0, 8'd8);
        tick();
        chk_out("cz0.hold", 16'h0000, 1'b0, 8'd8);

        // latch C into flag_q, then COND after a 3-cycle gap
        sif.instr_data  = I_EXEC;
        sif.instr_valid = 1'b1;
        tick();
        sif.instr_valid = 1'b0;
        sif.out_flags   = 4'b0010;
        tick();
        sif.out_flags = 4'b0000;
        tick();
        tick();
        sif.instr_data  = I_CC0;
        sif.instr_valid = 1'b1;
        tick();
        chk_out("cc0.gap", 16'h0000, 1'b0, 8'd9);
        tick();
        sif.instr_data = I_CC1;
        tick();
        sif.instr_valid = 1'b0;
        chk_out("cc1.gap", W_H0, 1'b1, 8'd9);
        tick();
        chk("cc1.count", 32'(sif.issue_count), 32'd10);

        // HALT absorbs everything until reset
        sif.instr_data  = I_HALT;
        sif.instr_valid = 1'b1;
        tick();
        chk("halt.halted", 32'(sif.halted), 32'd1);
        chk("halt.ready", 32'(sif.instr_ready), 32'd0);
        sif.instr_data = I_EXEC;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt.word", 32'(sif.ctrl_word), 32'd0);
            chk("halt.valid", 32'(sif.ctrl_valid), 32'd0);
        end
        chk("halt.count", 32'(sif.issue_count), 32'd10);
        sif.instr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("halt.rst", 32'(sif.halted), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("halt.rdy", 32'(sif.instr_ready), 32'd1);

        // 256 EXECs wrap issue_count
        sif.instr_data  = I_EXEC;
        sif.instr_valid = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        sif.instr_valid = 1'b0;
        chk_out("wrap.last", W_EXEC, 1'b1, 8'd255);
        tick();
        chk_out("wrap.zero", 16'h0000, 1'b0, 8'd0);

        // async reset in the middle of a REPEAT
        sif.instr_data  = I_RPT5;
        sif.instr_valid = 1'b1;
        tick();
        sif.instr_valid = 1'b0;
        tick();
        chk("mid.word", 32'(sif.ctrl_word), 32'(W_H0));
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("mid.rst", 16'h0000, 1'b0, 8'd0);
        chk("mid.ready", 32'(sif.instr_ready), 32'd1);
        reset_n = 1'b1;
        tick();
        tick();
        chk_out("mid.noresume", 16'h0000, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
